// File: rtl/alu_regfile_ctrl_if.sv
// ============================================================================
// Module   : alu_regfile_ctrl_if
// Brief    : Instruction handshake, ALU operand/result and data-out bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_regfile_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             InstValid;
    logic             InstReady;
    logic [7:0]       Inst;
    logic [WIDTH-1:0] NumA;
    logic [WIDTH-1:0] NumB;
    logic             ALUOP;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] DataOut;
    logic             DataOutValid;

    // Instruction source plus the downstream ALU that closes the Result loop
    modport master (
        output InstValid, Inst, Result,
        input  InstReady, NumA, NumB, ALUOP, DataOut, DataOutValid
    );

    modport slave (
        input  InstValid, Inst, Result,
        output InstReady, NumA, NumB, ALUOP, DataOut, DataOutValid
    );
endinterface

`default_nettype wire

// File: rtl/alu_regfile_ctrl.sv
// ============================================================================
// Module   : alu_regfile_ctrl
// Brief    : Operand/writeback controller with 4-entry register file feeding
//            an external combinational adder ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_regfile_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    alu_regfile_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOADI = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b10;

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [4];
    logic [WIDTH-1:0] r_num_a;
    logic [WIDTH-1:0] r_num_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [1:0]       r_rd;
    logic             r_wr_en;
    logic [WIDTH-1:0] w_imm;

    generate
        if (IMM_SIGNED) begin : g_imm_sext
            assign w_imm = {{(WIDTH-4){bus.Inst[3]}}, bus.Inst[3:0]};
        end else begin : g_imm_zext
            assign w_imm = {{(WIDTH-4){1'b0}}, bus.Inst[3:0]};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_regs       <= '{default: '0};
            r_num_a      <= '0;
            r_num_b      <= '0;
            r_result     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_rd         <= 2'd0;
            r_wr_en      <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.InstValid) begin
                        r_rd <= bus.Inst[5:4];
                        case (bus.Inst[7:6])
                            OP_ADD: begin
                                // Operands captured now, so rd==rs/rt sees the old value
                                r_num_a <= r_regs[bus.Inst[3:2]];
                                r_num_b <= r_regs[bus.Inst[1:0]];
                                r_wr_en <= 1'b1;
                                r_state <= S_EXEC;
                            end
                            OP_LOADI: begin
                                r_result <= w_imm;
                                r_wr_en  <= 1'b1;
                                r_state  <= S_WB;
                            end
                            OP_NOP: begin
                                r_wr_en <= 1'b0;
                                r_state <= S_WB;
                            end
                            default: begin
                                r_dout       <= r_regs[bus.Inst[3:2]];
                                r_dout_valid <= 1'b1;
                                r_wr_en      <= 1'b0;
                                r_state      <= S_WB;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    r_result <= bus.Result;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (r_wr_en) begin
                        r_regs[r_rd] <= r_result;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.InstReady    = (r_state == S_IDLE) && !RESET;
    assign bus.NumA         = r_num_a;
    assign bus.NumB         = r_num_b;
    assign bus.ALUOP        = 1'b0;
    assign bus.DataOut      = r_dout;
    assign bus.DataOutValid = r_dout_valid;

endmodule

`default_nettype wire
